// File: rtl/dt_pkg.sv
// dt_pkg: shared date/time field positions, ASCII framing constants and error codes
package dt_pkg;
   localparam int FRAME_LEN = 16;
   localparam int POS_SECOND = 0;
   localparam int POS_MINUTE = 1;
   localparam int POS_HOUR = 2;
   localparam int POS_DAY = 3;
   localparam int POS_MONTH = 4;
   localparam int POS_YEAR = 5;
   localparam logic [7:0] SLASH = 8'h2F;
   localparam logic [7:0] COLON = 8'h3A;
   localparam logic [7:0] DIGIT_BASE = 8'h30;
   localparam logic [7:0] HIDDEN_BASE = 8'h10;
   typedef enum logic [2:0] {
      ERR_NONE = 3'd0,
      ERR_TRUNC = 3'd1,
      ERR_BAD_CHAR = 3'd2,
      ERR_RANGE = 3'd3,
      ERR_HIDDEN = 3'd4
   } err_t;
   function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
      return ({3'd0, tens} << 3) + ({3'd0, tens} << 1) + {3'd0, units};
   endfunction
endpackage

// File: rtl/dt_digit_decode.sv
// dt_digit_decode: classifies one stream byte as visible/hidden digit and extracts its value
module dt_digit_decode
   import dt_pkg::*;
(
   input  logic [7:0] ascii,
   output logic       is_digit,
   output logic       hidden,
   output logic [3:0] value
);
   always_comb begin
      hidden = ascii[7:4] == HIDDEN_BASE[7:4];
      value = ascii[3:0];
      is_digit = (hidden || ascii[7:4] == DIGIT_BASE[7:4]) && ascii[3:0] <= 4'd9;
   end
endmodule

// File: rtl/date_time_ascii_parser.sv
// date_time_ascii_parser: parses "YY/MM/DDHH:MM:SS" byte frames into binary date/time fields
module date_time_ascii_parser #(
   parameter int FRAME_LEN = 16
) (
   input  logic       clk_27mhz,
   input  logic       reset,
   input  logic [7:0] ascii_in,
   input  logic       ascii_in_ready,
   output logic [6:0] year,
   output logic [3:0] month,
   output logic [4:0] day,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [5:0] hidden,
   output logic       frame_valid,
   output logic       frame_error,
   output logic [2:0] err_code
);
   import dt_pkg::*;
   typedef enum logic [1:0] {IDLE, RECV, CHECK, DRAIN} state_t;
   state_t state;
   logic [3:0] pos, wpos;
   logic prev_ready, trunc, bad, start, take, byte_bad;
   logic is_digit, dec_hidden;
   logic [3:0] dec_value;
   logic [4:0] cap [FRAME_LEN];
   logic [6:0] yr_b, mo_b, dy_b, hr_b, mi_b, se_b, dim;
   logic mism, range_bad;
   logic [5:0] hid_n;
   err_t code;

   dt_digit_decode u_dec (
      .ascii(ascii_in),
      .is_digit(is_digit),
      .hidden(dec_hidden),
      .value(dec_value)
   );

   // A truncated frame's CHECK cycle doubles as IDLE so a resend one low cycle later is caught
   always_comb begin
      start = ascii_in_ready && !prev_ready && (state == IDLE || state == CHECK);
      take = start || (state == RECV && ascii_in_ready);
      wpos = start ? 4'd0 : pos;
      byte_bad = (wpos == 4'd2 || wpos == 4'd5) ? ascii_in != SLASH :
                 (wpos == 4'd10 || wpos == 4'd13) ? ascii_in != COLON : !is_digit;
      yr_b = bcd2bin(cap[0][3:0], cap[1][3:0]);
      mo_b = bcd2bin(cap[3][3:0], cap[4][3:0]);
      dy_b = bcd2bin(cap[6][3:0], cap[7][3:0]);
      hr_b = bcd2bin(cap[8][3:0], cap[9][3:0]);
      mi_b = bcd2bin(cap[11][3:0], cap[12][3:0]);
      se_b = bcd2bin(cap[14][3:0], cap[15][3:0]);
      dim = mo_b == 7'd2 ? (yr_b[1:0] == 2'd0 ? 7'd29 : 7'd28) :
            (mo_b == 7'd4 || mo_b == 7'd6 || mo_b == 7'd9 || mo_b == 7'd11) ? 7'd30 : 7'd31;
      range_bad = mo_b < 7'd1 || mo_b > 7'd12 || dy_b < 7'd1 || dy_b > dim ||
                  hr_b > 7'd23 || mi_b > 7'd59 || se_b > 7'd59;
      mism = cap[0][4] != cap[1][4] || cap[3][4] != cap[4][4] || cap[6][4] != cap[7][4] ||
             cap[8][4] != cap[9][4] || cap[11][4] != cap[12][4] || cap[14][4] != cap[15][4];
      hid_n = '0;
      hid_n[POS_SECOND] = cap[14][4];
      hid_n[POS_MINUTE] = cap[11][4];
      hid_n[POS_HOUR] = cap[8][4];
      hid_n[POS_DAY] = cap[6][4];
      hid_n[POS_MONTH] = cap[3][4];
      hid_n[POS_YEAR] = cap[0][4];
      code = trunc ? ERR_TRUNC : bad ? ERR_BAD_CHAR : mism ? ERR_HIDDEN :
             range_bad ? ERR_RANGE : ERR_NONE;
   end

   always_ff @(posedge clk_27mhz) begin
      if (take) cap[wpos] <= {dec_hidden, dec_value};
   end

   always_ff @(posedge clk_27mhz or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pos <= '0;
         prev_ready <= 1'b1;
         trunc <= 1'b0;
         bad <= 1'b0;
         year <= '0;
         month <= 4'd1;
         day <= 5'd1;
         hour <= '0;
         minute <= '0;
         second <= '0;
         hidden <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         err_code <= '0;
      end else begin
         prev_ready <= ascii_in_ready;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         if (take) begin
            pos <= wpos + 4'd1;
            bad <= start ? byte_bad : bad | byte_bad;
         end
         if (start) trunc <= 1'b0;
         case (state)
            IDLE: if (start) state <= RECV;
            RECV: begin
               if (!ascii_in_ready) begin
                  trunc <= 1'b1;
                  state <= CHECK;
               end else if (pos == 4'(FRAME_LEN - 1)) state <= CHECK;
            end
            CHECK: begin
               err_code <= code;
               if (code == ERR_NONE) begin
                  year <= yr_b;
                  month <= mo_b[3:0];
                  day <= dy_b[4:0];
                  hour <= hr_b[4:0];
                  minute <= mi_b[5:0];
                  second <= se_b[5:0];
                  hidden <= hid_n;
                  frame_valid <= 1'b1;
               end else frame_error <= 1'b1;
               state <= start ? RECV : ascii_in_ready ? DRAIN : IDLE;
            end
            default: if (!ascii_in_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_date_time_ascii_parser.sv
// tb_date_time_ascii_parser: directed self-checking bench for the date/time frame parser
module tb_date_time_ascii_parser;
   logic clk_27mhz = 1'b0;
   logic reset = 1'b1;
   logic [7:0] ascii_in = '0;
   logic ascii_in_ready = 1'b0;
   logic [6:0] year;
   logic [3:0] month;
   logic [4:0] day, hour;
   logic [5:0] minute, second, hidden;
   logic frame_valid, frame_error;
   logic [2:0] err_code;
   logic [7:0] f [16];
   int checks = 0;
   int errors = 0;

   date_time_ascii_parser dut (
      .clk_27mhz(clk_27mhz),
      .reset(reset),
      .ascii_in(ascii_in),
      .ascii_in_ready(ascii_in_ready),
      .year(year),
      .month(month),
      .day(day),
      .hour(hour),
      .minute(minute),
      .second(second),
      .hidden(hidden),
      .frame_valid(frame_valid),
      .frame_error(frame_error),
      .err_code(err_code)
   );

   always #5 clk_27mhz = ~clk_27mhz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_fields(input string tag, input int y, mo, d, h, mi, s, hid);
      chk({tag, " year"}, 32'(year), 32'(y));
      chk({tag, " month"}, 32'(month), 32'(mo));
      chk({tag, " day"}, 32'(day), 32'(d));
      chk({tag, " hour"}, 32'(hour), 32'(h));
      chk({tag, " minute"}, 32'(minute), 32'(mi));
      chk({tag, " second"}, 32'(second), 32'(s));
      chk({tag, " hidden"}, 32'(hidden), 32'(hid));
   endtask

   task automatic set_frame(input string s);
      for (int i = 0; i < 16; i++) f[i] = s[i];
   endtask

   task automatic push(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         ascii_in = f[i];
         ascii_in_ready = 1'b1;
         @(posedge clk_27mhz);
         #1;
      end
   endtask

   // Called 1ns after the edge that sampled the last byte (edge N), ready already low
   task automatic result(input string tag, input logic v, input int code);
      chk({tag, " early pulse"}, 32'(frame_valid | frame_error), 0);
      @(posedge clk_27mhz);
      #1;
      chk({tag, " valid"}, 32'(frame_valid), 32'(v));
      chk({tag, " error"}, 32'(frame_error), 32'(!v));
      chk({tag, " err_code"}, 32'(err_code), 32'(code));
      @(posedge clk_27mhz);
      #1;
      chk({tag, " pulse width"}, 32'(frame_valid | frame_error), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk_27mhz);
      #1;
      chk_fields("reset", 0, 1, 1, 0, 0, 0, 0);
      chk("reset valid", 32'(frame_valid), 0);
      chk("reset error", 32'(frame_error), 0);
      chk("reset err_code", 32'(err_code), 0);
      reset = 1'b0;
      @(posedge clk_27mhz);
      #1;

      set_frame("12/11/2421:07:49");
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("basic", 1'b1, 0);
      chk_fields("basic", 12, 11, 24, 21, 7, 49, 0);

      f[0] = 8'h11;
      f[1] = 8'h12;
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("hidden year", 1'b1, 0);
      chk_fields("hidden year", 12, 11, 24, 21, 7, 49, 6'b100000);

      set_frame("12/02/2900:00:00");
      push(0, 9);
      ascii_in_ready = 1'b0;
      @(posedge clk_27mhz);
      #1;
      chk("trunc early", 32'(frame_error), 0);
      ascii_in = f[0];
      ascii_in_ready = 1'b1;
      @(posedge clk_27mhz);
      #1;
      chk("trunc error", 32'(frame_error), 1);
      chk("trunc valid", 32'(frame_valid), 0);
      chk("trunc err_code", 32'(err_code), 1);
      chk_fields("trunc kept", 12, 11, 24, 21, 7, 49, 6'b100000);
      push(1, 16);
      ascii_in_ready = 1'b0;
      result("resend leap", 1'b1, 0);
      chk_fields("resend leap", 12, 2, 29, 0, 0, 0, 0);

      set_frame("13/02/2900:00:00");
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("feb29 nonleap", 1'b0, 3);
      chk_fields("feb29 kept", 12, 2, 29, 0, 0, 0, 0);

      set_frame("13/02/2823:59:59");
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("feb28 bounds", 1'b1, 0);
      chk_fields("feb28 bounds", 13, 2, 28, 23, 59, 59, 0);

      set_frame("12/13/0100:00:00");
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("month13", 1'b0, 3);

      set_frame("12/04/3100:00:00");
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("apr31", 1'b0, 3);

      set_frame("12/01/0124:00:00");
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("hour24", 1'b0, 3);

      set_frame("12/02/2900:00:00");
      f[2] = 8'h2D;
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("bad sep", 1'b0, 2);

      set_frame("12/02/2900:00:00");
      f[11] = 8'h10;
      f[12] = 8'h35;
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("hid mismatch", 1'b0, 4);

      f[2] = 8'h2D;
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("bad over mismatch", 1'b0, 2);
      chk_fields("errors kept", 13, 2, 28, 23, 59, 59, 0);

      set_frame("12/11/2421:07:49");
      push(0, 7);
      reset = 1'b1;
      #1;
      chk_fields("mid reset", 0, 1, 1, 0, 0, 0, 0);
      chk("mid reset code", 32'(err_code), 0);
      push(7, 10);
      reset = 1'b0;
      push(10, 16);
      for (int i = 0; i < 12; i++) begin
         ascii_in = f[i];
         @(posedge clk_27mhz);
         #1;
         chk("post reset quiet", 32'(frame_valid | frame_error), 0);
      end
      chk_fields("post reset", 0, 1, 1, 0, 0, 0, 0);
      ascii_in_ready = 1'b0;
      @(posedge clk_27mhz);
      #1;
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("after reset", 1'b1, 0);
      chk_fields("after reset", 12, 11, 24, 21, 7, 49, 0);

      set_frame("08/09/1505:04:03");
      push(0, 16);
      ascii_in = 8'h41;
      @(posedge clk_27mhz);
      #1;
      chk("burst valid", 32'(frame_valid), 1);
      chk_fields("burst", 8, 9, 15, 5, 4, 3, 0);
      ascii_in_ready = 1'b0;
      @(posedge clk_27mhz);
      #1;
      chk("burst extra", 32'(frame_valid | frame_error), 0);
      set_frame("99/12/3123:59:59");
      push(0, 16);
      ascii_in_ready = 1'b0;
      result("after burst", 1'b1, 0);
      chk_fields("after burst", 99, 12, 31, 23, 59, 59, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/date_time_ascii_parser.md
# date_time_ascii_parser

Receive-side counterpart of the date/time ASCII streamer. It consumes the 16-byte date/time character stream `YY/MM/DDHH:MM:SS` (one byte per cycle while ready is high), checks it, and converts it back into binary date/time fields plus per-field "hidden" (cursor-blank) flags. It sits wherever a date/time text frame arrives, such as a remote unit's clock sync or a loopback check of the local streamer, and it feeds the UI/clock logic with atomically updated fields.

## Interface
- `FRAME_LEN`, 16: bytes per frame; fixed, not to be overridden.
- `clk_27mhz`  in  1  system clock, 27 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `ascii_in`  in  8  stream byte, sampled every cycle `ascii_in_ready`=1.
- `ascii_in_ready`  in  1  high for consecutive cycles while a frame is streamed.
- `year`  out  7  0–99.
- `month`  out  4  1–12.
- `day`  out  5  1–31.
- `hour`  out  5  0–23.
- `minute`  out  6  0–59.
- `second`  out  6  0–59.
- `hidden`  out  6  per-field hidden flag. Bit index: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year.
- `frame_valid`  out  1  one-cycle pulse; fields were updated.
- `frame_error`  out  1  one-cycle pulse; frame rejected, fields unchanged.
- `err_code`  out  3  0 none, 1 truncated, 2 bad character, 3 out of range, 4 hidden mismatch. Held until the next pulse.

## Operation
- Byte positions:
  - 0–1 year, 2 `/` (0x2F), 3–4 month, 5 `/`.
  - 6–7 day, 8–9 hour, 10 `:` (0x3A).
  - 11–12 minute, 13 `:`, 14–15 second.
- Digit bytes:
  - 0x30–0x39 is a visible digit.
  - 0x10–0x19 is a hidden digit (bit 5 cleared). Value is the low nibble.
  - Anything else at a digit position, or a wrong separator, is a bad character.
- A field's two digits must share the same hidden state; otherwise hidden mismatch.
- Binary value = tens·10 + units, computed as (tens<<3)+(tens<<1)+units in 7 bits, truncated to the field width.
- Range check:
  - month 1–12, hour ≤23, minute/second ≤59.
  - day 1..days(month, year). Feb has 29 days when year[1:0]==0, else 28. Months 1,3,5,7,8,10,12 have 31; the rest have 30.
- Error priority: truncated > bad character > hidden mismatch > range. Errors are accumulated during the frame and reported once.
- FSM:
  - IDLE: start when `ascii_in_ready`=1 and the previous-cycle ready register = 0. Consume byte 0, pos←1, go to RECV.
  - RECV: while ready=1, consume byte at pos, pos++. After byte 15 is consumed, go to CHECK. If ready=0 before byte 15, pulse error with code 1 and go to IDLE.
  - CHECK: evaluate. On success, load all fields and `hidden` together and pulse `frame_valid`; otherwise pulse `frame_error`. If ready=1, go to DRAIN; else go to IDLE.
  - DRAIN: ignore bytes until ready=0, then go to IDLE. Byte 17+ of a burst is silently dropped; it is not an error.
- Reset values:
  - year 0, month 1, day 1, hour 0, minute 0, second 0.
  - hidden 0, frame_valid 0, frame_error 0, err_code 0.
  - FSM in IDLE.
  - The previous-ready register resets to 1, so a stream already in progress at reset release is ignored until ready goes low.

## Timing
- Byte k is sampled at the rising edge where ready=1.
- When the last byte is sampled at edge N, CHECK runs during the following cycle. Fields, `hidden`, `err_code`, and the valid/error pulse update at edge N+1, and the pulse is high for exactly one cycle.
- Truncation: when ready is sampled low at edge M in RECV, the error pulse is high from edge M+1 for one cycle.
- A new frame may start one cycle after ready falls, because one low cycle suffices.
- Reset mid-frame aborts immediately; no pulse is produced.

## Structure
- Shared package `dt_pkg`:
  - field position constants (POS_SECOND..POS_YEAR = 0..5), reused by the clock/cursor logic;
  - ASCII constants (SLASH 0x2F, COLON 0x3A, DIGIT_BASE 0x30, HIDDEN_BASE 0x10);
  - err_code values and FRAME_LEN.
- Sub-module `dt_digit_decode` (combinational): byte → {is_digit, hidden, value[3:0]}. Instantiated once in the parser.
- Top level: FSM, position counter, per-field tens/units capture, range checker, output registers.

## Test plan
- "12/11/2421:07:49" streamed over 16 consecutive cycles -> year 12, month 11, day 24, hour 21, minute 7, second 49, hidden 0. `frame_valid` pulses once at edge N+1; err_code 0.
- Same frame with year bytes 0x11, 0x12 -> year 12, hidden 6'b100000, valid.
- Ready drops after 9 bytes -> `frame_error` with err_code 1; outputs keep their prior values. An immediate re-sent full frame is accepted.
- Day/month range checks:
  - "12/02/2900:00:00" -> valid (leap year).
  - "13/02/2900:00:00" -> error, code 3.
  - "12/13/0100:00:00" -> code 3.
  - byte 2 = 0x2D -> code 2.
  - minute digits 0x10, 0x35 -> code 4.
- Reset asserted at byte 7, with ready held high through reset release -> all outputs at reset values and no pulse until ready goes low and a full frame arrives.
- 17-cycle burst -> one valid for the first 16 bytes, 17th ignored. Next frame after one low cycle -> second valid.
